// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_ST_W = 2;

    // Access sequencer states
    localparam logic [ARB_ST_W-1:0] ARB_IDLE   = 2'd0;
    localparam logic [ARB_ST_W-1:0] ARB_ACCESS = 2'd1;
    localparam logic [ARB_ST_W-1:0] ARB_DONE   = 2'd2;

    // Requester port indices
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick: on a tie, the port not served last wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       winner
);

    // Winner selection
    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (req[0] && req[1]) begin
            winner = ~last_gnt;
        end else if (req[1]) begin
            winner = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU (port 0) and the loader (port 1) using a
// fixed IDLE -> ACCESS -> DONE sequence per access and round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    logic [ARB_ST_W-1:0] state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_gnt_q, last_gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          ack_q, ack_d;
    logic                busy_q, busy_d;

    logic pick_valid;
    logic pick_winner;

    arb_rr2 u_rr (
        .req      ({req1, req0}),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    // Next-state, request latching and registered-output decode
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    we_d    = pick_winner ? we1    : we0;
                    addr_d  = pick_winner ? addr1  : addr0;
                    wdata_d = pick_winner ? wdata1 : wdata0;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (!we_q) begin
                    rdata_d = mem_data_out;
                end
                state_d = ARB_DONE;
            end
            ARB_DONE: begin
                last_gnt_d = owner_q;
                state_d    = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
        gnt_d  = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
        ack_d  = (state_d == ARB_DONE) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= PORT_CPU;
            last_gnt_q <= PORT_LDR;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            gnt_q      <= 2'b00;
            ack_q      <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    // Memory strobes are gated with reset so nothing reaches memory while resetting
    assign mem_read    = (state_q == ARB_ACCESS) && !we_q && !reset;
    assign mem_write   = (state_q == ARB_ACCESS) &&  we_q && !reset;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign ack0  = ack_q[0];
    assign ack1  = ack_q[1];
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule
